// File: rtl/dma_axi_wr_if_pkg.sv
// Shared DMA write-path types and AXI constants used by the AXI4 write-master interface.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 512
`endif

package dma_axi_wr_if_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = `DMA_DATA_WIDTH;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [7:0]            axi_len_t;
  typedef logic [2:0]            axi_size_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;
  typedef logic [1:0]            axi_burst_t;
  typedef logic [1:0]            axi_resp_t;

  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_resp_t  AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t  AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_if_st_t;

  typedef enum logic [1:0] {
    WR_ERR_SLVERR  = 2'd0,
    WR_ERR_DECERR  = 2'd1,
    WR_ERR_TIMEOUT = 2'd2
  } dma_wr_err_src_t;

  // Maps an erroring BRESP (bit 1 set) onto the reported error source.
  function automatic dma_wr_err_src_t resp_err_src(input axi_resp_t resp);
    return (resp == AXI_RESP_DECERR) ? WR_ERR_DECERR : WR_ERR_SLVERR;
  endfunction

endpackage

// File: rtl/dma_axi_wr_if.sv
// AXI4 write master for the DMA write path: one INCR burst in flight, AW -> W beats -> B.
// Optional B-response watchdog enabled by defining DMA_WR_RESP_TIMEOUT_EN.
module dma_axi_wr_if
  import dma_axi_wr_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = `DMA_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_alen_i,
  input  logic [2:0]        req_size_i,
  input  logic [STRB_W-1:0] req_strb_i,
  output logic              req_ready_o,
  output logic              req_finish_o,
  input  logic [DATA_W-1:0] wbuf_data_i,
  input  logic              wbuf_valid_i,
  output logic              wbuf_ready_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [7:0]        m_awlen_o,
  output logic [2:0]        m_awsize_o,
  output logic [1:0]        m_awburst_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [STRB_W-1:0] m_wstrb_o,
  output logic              m_wlast_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  output logic              err_valid_o,
  output logic [1:0]        err_src_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("dma_axi_wr_if: TIMEOUT_CYC must be nonzero");
  end

  wr_if_st_t         state_r, state_s;
  logic [8:0]        beat_cnt_r, beat_cnt_s;
  logic [ADDR_W-1:0] addr_r;
  axi_len_t          len_r;
  axi_size_t         size_r;
  logic [STRB_W-1:0] strb_r;
  logic              capture_s;
  logic              last_beat_s;

  assign last_beat_s = (beat_cnt_r == {1'b0, len_r});

  assign m_awaddr_o  = addr_r;
  assign m_awlen_o   = len_r;
  assign m_awsize_o  = size_r;
  assign m_awburst_o = AXI_BURST_INCR;

`ifdef DMA_WR_RESP_TIMEOUT_EN
  logic [31:0] to_cnt_r;
  logic        timeout_s;

  assign timeout_s = (to_cnt_r == TIMEOUT_CYC);

  // Watchdog counts consecutive RESP cycles; any exit from RESP clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_r <= 32'd0;
    end else if ((state_r == WR_RESP) && (state_s == WR_RESP)) begin
      to_cnt_r <= to_cnt_r + 32'd1;
    end else begin
      to_cnt_r <= 32'd0;
    end
  end
`endif

  // State, beat counter and the burst descriptor captured at request time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= WR_IDLE;
      beat_cnt_r <= 9'd0;
      addr_r     <= '0;
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      strb_r     <= '0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      if (capture_s) begin
        addr_r <= req_addr_i;
        len_r  <= req_alen_i;
        size_r <= req_size_i;
        strb_r <= req_strb_i;
      end
    end
  end

  // Next-state and handshake outputs; W data is only steered through in DATA.
  always_comb begin
    state_s      = state_r;
    beat_cnt_s   = beat_cnt_r;
    capture_s    = 1'b0;
    req_ready_o  = 1'b0;
    req_finish_o = 1'b0;
    wbuf_ready_o = 1'b0;
    m_awvalid_o  = 1'b0;
    m_wdata_o    = '0;
    m_wstrb_o    = '0;
    m_wlast_o    = 1'b0;
    m_wvalid_o   = 1'b0;
    m_bready_o   = 1'b0;
    err_valid_o  = 1'b0;
    err_src_o    = 2'd0;
    err_addr_o   = '0;
    case (state_r)
      WR_IDLE: begin
`ifdef DMA_WR_RESP_TIMEOUT_EN
        // Soak up any B response that shows up after a watchdog abort.
        m_bready_o = 1'b1;
`endif
        if (req_valid_i) begin
          req_ready_o = 1'b1;
          capture_s   = 1'b1;
          state_s     = WR_ADDR;
        end else begin
          state_s = WR_IDLE;
        end
      end
      WR_ADDR: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) begin
          state_s = WR_DATA;
        end else begin
          state_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        m_wvalid_o   = wbuf_valid_i;
        m_wdata_o    = wbuf_data_i;
        m_wstrb_o    = strb_r;
        m_wlast_o    = last_beat_s;
        wbuf_ready_o = m_wready_i;
        if (wbuf_valid_i && m_wready_i) begin
          if (last_beat_s) begin
            beat_cnt_s = 9'd0;
            state_s    = WR_RESP;
          end else begin
            beat_cnt_s = beat_cnt_r + 9'd1;
          end
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      WR_RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          req_finish_o = 1'b1;
          state_s      = WR_IDLE;
          if (m_bresp_i[1]) begin
            err_valid_o = 1'b1;
            err_src_o   = resp_err_src(m_bresp_i);
            err_addr_o  = addr_r;
          end else begin
            err_valid_o = 1'b0;
          end
`ifdef DMA_WR_RESP_TIMEOUT_EN
        end else if (timeout_s) begin
          req_finish_o = 1'b1;
          err_valid_o  = 1'b1;
          err_src_o    = WR_ERR_TIMEOUT;
          err_addr_o   = addr_r;
          state_s      = WR_IDLE;
`endif
        end else begin
          state_s = WR_RESP;
        end
      end
      default: begin
        state_s    = WR_IDLE;
        beat_cnt_s = 9'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_axi_wr_if.sv
// Self-checking bench for dma_axi_wr_if: vector table, hand sequences and randomized bursts.
module tb_dma_axi_wr_if;

  localparam int DATA_W = 512;
  localparam int STRB_W = DATA_W / 8;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [7:0]        req_alen_i;
  logic [2:0]        req_size_i;
  logic [STRB_W-1:0] req_strb_i;
  logic              req_ready_o, req_finish_o;
  logic [DATA_W-1:0] wbuf_data_i;
  logic              wbuf_valid_i, wbuf_ready_o;
  logic [ADDR_W-1:0] m_awaddr_o;
  logic [7:0]        m_awlen_o;
  logic [2:0]        m_awsize_o;
  logic [1:0]        m_awburst_o;
  logic              m_awvalid_o, m_awready_i;
  logic [DATA_W-1:0] m_wdata_o;
  logic [STRB_W-1:0] m_wstrb_o;
  logic              m_wlast_o, m_wvalid_o, m_wready_i;
  logic [1:0]        m_bresp_i;
  logic              m_bvalid_i, m_bready_o;
  logic              err_valid_o;
  logic [1:0]        err_src_o;
  logic [ADDR_W-1:0] err_addr_o;

  int errors = 0;
  int checks = 0;

  dma_axi_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_alen_i(req_alen_i),
    .req_size_i(req_size_i), .req_strb_i(req_strb_i),
    .req_ready_o(req_ready_o), .req_finish_o(req_finish_o),
    .wbuf_data_i(wbuf_data_i), .wbuf_valid_i(wbuf_valid_i), .wbuf_ready_o(wbuf_ready_o),
    .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
    .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .err_valid_o(err_valid_o), .err_src_o(err_src_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [2:0]  size;
    logic [63:0] strb;
    logic [1:0]  bresp;
    int          aw_dly;   // cycles awready is held low once awvalid appears
    int          wr_mode;  // 0 always ready, 1 toggling, 2 random
    bit          gap;      // buffer empty for 4 cycles at the third beat
    int          b_dly;    // cycles bvalid is held low in the response phase
    int          exp_lat;  // ready-to-finish cycles, -1 when not fixed
    bit          exp_err;
    logic [1:0]  exp_src;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [14:0] outs_zero_vec();
    return {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o, req_ready_o, req_finish_o,
            err_valid_o, wbuf_ready_o, |m_awaddr_o, |m_awlen_o, |m_awsize_o,
            |m_wstrb_o, |m_wdata_o, |err_addr_o, |err_src_o};
  endfunction

  task automatic idle_inputs();
    req_valid_i  = 1'b0;
    wbuf_valid_i = 1'b0;
    m_awready_i  = 1'b0;
    m_wready_i   = 1'b0;
    m_bvalid_i   = 1'b0;
    m_bresp_i    = 2'b00;
  endtask

  // Runs one burst end to end and checks it against the expected AXI behaviour.
  task automatic run_burst(input string nm, input vec_t v);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int beats = 0, readies = 0, finishes = 0, errs = 0;
    int t_ready = -1, t_fin = -1, awv_cnt = 0, b_cnt = 0, gap_left;
    bit aw_done = 1'b0, in_resp = 1'b0, awv_prev = 1'b0;
    bit aw_bad = 1'b0, w_early = 1'b0, last_bad = 1'b0, strb_bad = 1'b0;
    bit overlap = 1'b0, stall_bad = 1'b0, wbr_bad = 1'b0, data_ok;
    logic [1:0] got_src = 2'd0;
    logic [31:0] got_eaddr = 32'd0;
    gap_left = v.gap ? 4 : 0;
    for (int i = 0; i <= int'(v.alen); i++) exp_q.push_back(rand_word());
    for (int cyc = 0; cyc < 3000 && finishes == 0; cyc++) begin
      @(negedge clk);
      req_valid_i  = (cyc == 0);
      req_addr_i   = v.addr;
      req_alen_i   = v.alen;
      req_size_i   = v.size;
      req_strb_i   = v.strb;
      m_awready_i  = (awv_cnt >= v.aw_dly);
      wbuf_valid_i = !(aw_done && beats == 2 && gap_left > 0);
      wbuf_data_i  = (beats <= int'(v.alen)) ? exp_q[beats] : rand_word();
      case (v.wr_mode)
        0:       m_wready_i = 1'b1;
        1:       m_wready_i = cyc[0];
        default: m_wready_i = 1'($urandom_range(0, 1));
      endcase
      m_bvalid_i = in_resp && (b_cnt >= v.b_dly);
      m_bresp_i  = v.bresp;
      #1;
      if (req_ready_o) begin readies++; t_ready = cyc; end
      if (req_ready_o && req_finish_o) overlap = 1'b1;
      if (m_awvalid_o) begin
        awv_cnt++;
        if (m_awaddr_o !== v.addr || m_awlen_o !== v.alen || m_awsize_o !== v.size ||
            m_awburst_o !== 2'b01) aw_bad = 1'b1;
      end
      if (awv_prev && !aw_done && !m_awvalid_o) aw_bad = 1'b1;
      if (m_wvalid_o && !aw_done) w_early = 1'b1;
      if (m_wvalid_o && !wbuf_valid_i) stall_bad = 1'b1;
      if (m_wvalid_o && wbuf_ready_o !== m_wready_i) wbr_bad = 1'b1;
      if (m_wvalid_o && m_wready_i) begin
        if (m_wlast_o !== (beats == int'(v.alen))) last_bad = 1'b1;
        if (m_wstrb_o !== v.strb) strb_bad = 1'b1;
        got_q.push_back(m_wdata_o);
        beats++;
        if (beats == int'(v.alen) + 1) in_resp = 1'b1;
      end else if (in_resp && !m_bvalid_i) begin
        b_cnt++;
      end
      if (!aw_done && gap_left == 4 && beats == 2 && aw_done) gap_left = 4;
      if (aw_done && beats == 2 && !wbuf_valid_i) gap_left--;
      if (err_valid_o) begin errs++; got_src = err_src_o; got_eaddr = err_addr_o; end
      if (req_finish_o) begin finishes++; t_fin = cyc; end
      if (m_awvalid_o && m_awready_i) aw_done = 1'b1;
      awv_prev = m_awvalid_o;
    end
    data_ok = (got_q.size() == exp_q.size());
    if (data_ok) foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) data_ok = 1'b0;
    chk({nm, "_ready_cnt"}, 64'(readies), 64'd1);
    chk({nm, "_finish_cnt"}, 64'(finishes), 64'd1);
    chk({nm, "_beats"}, 64'(beats), 64'(int'(v.alen) + 1));
    chk({nm, "_wdata"}, 64'(data_ok), 64'd1);
    chk({nm, "_wlast"}, 64'(last_bad), 64'd0);
    chk({nm, "_wstrb"}, 64'(strb_bad), 64'd0);
    chk({nm, "_aw_payload"}, 64'(aw_bad), 64'd0);
    chk({nm, "_w_before_aw"}, 64'(w_early), 64'd0);
    chk({nm, "_w_stall"}, 64'(stall_bad), 64'd0);
    chk({nm, "_wbuf_ready"}, 64'(wbr_bad), 64'd0);
    chk({nm, "_ready_finish_overlap"}, 64'(overlap), 64'd0);
    chk({nm, "_err_cnt"}, 64'(errs), 64'(v.exp_err));
    if (v.exp_err) begin
      chk({nm, "_err_src"}, 64'(got_src), 64'(v.exp_src));
      chk({nm, "_err_addr"}, 64'(got_eaddr), 64'(v.addr));
    end
    if (v.exp_lat >= 0) chk({nm, "_latency"}, 64'(t_fin - t_ready), 64'(v.exp_lat));
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    idle_inputs();
    req_addr_i  = '0;
    req_alen_i  = '0;
    req_size_i  = '0;
    req_strb_i  = '0;
    wbuf_data_i = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(outs_zero_vec()), 64'd0);
    chk("reset_awburst", 64'(m_awburst_o), 64'd1);
    @(negedge clk);
    rstn = 1'b1;

    //            addr          alen    size  strb                    bresp  awd wr gap bd lat err src
    vecs[0] = '{32'h0000_1000, 8'd0,   3'd6, 64'hFFFF_0000_0000_0000, 2'b00, 0, 0, 0, 0, 3, 0, 2'd0};
    vecs[1] = '{32'h0000_3040, 8'd1,   3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 0, 0, 0, 4, 1, 2'd0};
    vecs[2] = '{32'h0000_4000, 8'd2,   3'd5, 64'h0000_0000_FFFF_FFFF, 2'b11, 0, 0, 0, 0, 5, 1, 2'd1};
    vecs[3] = '{32'h0000_5000, 8'd0,   3'd6, 64'h0F0F_0F0F_0F0F_0F0F, 2'b01, 0, 0, 0, 0, 3, 0, 2'd0};
    vecs[4] = '{32'h0000_6000, 8'd3,   3'd6, 64'hFFFF_FFFF_0000_0000, 2'b00, 5, 0, 1, 0, -1, 0, 2'd0};
    vecs[5] = '{32'h0000_2000, 8'd255, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 1, 0, 0, -1, 0, 2'd0};
    vecs[6] = '{32'h0000_7000, 8'd4,   3'd4, 64'h0000_0000_0000_FFFF, 2'b10, 2, 2, 0, 3, -1, 1, 2'd0};
    foreach (vecs[i]) run_burst($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a data phase abandons the burst silently.
    begin
      int fired = 0;
      int fins = 0;
      for (int c = 0; c < 200 && fired < 2; c++) begin
        @(negedge clk);
        req_valid_i  = (c == 0);
        req_addr_i   = 32'h0000_8000;
        req_alen_i   = 8'd7;
        req_size_i   = 3'd6;
        req_strb_i   = '1;
        m_awready_i  = 1'b1;
        m_wready_i   = 1'b1;
        wbuf_valid_i = 1'b1;
        wbuf_data_i  = rand_word();
        m_bvalid_i   = 1'b0;
        #1;
        if (req_finish_o) fins++;
        if (m_wvalid_o && m_wready_i) fired++;
      end
      chk("rst_mid_beats_before", 64'(fired), 64'd2);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_outs", 64'(outs_zero_vec()), 64'd0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (req_finish_o) fins++;
      end
      chk("rst_mid_no_finish", 64'(fins), 64'd0);
      idle_inputs();
      rstn = 1'b1;
      rv = '{32'h0000_9000, 8'd3, 3'd6, 64'h00FF_00FF_00FF_00FF, 2'b00, 0, 0, 0, 0, 6, 0, 2'd0};
      run_burst("after_rst", rv);
    end

`ifdef DMA_WR_RESP_TIMEOUT_EN
    // Withheld B response: watchdog aborts after 16 response cycles.
    begin
      int resp_cyc = 0;
      bit done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        req_valid_i  = (c == 0);
        req_addr_i   = 32'h0000_A000;
        req_alen_i   = 8'd0;
        m_awready_i  = 1'b1;
        m_wready_i   = 1'b1;
        wbuf_valid_i = 1'b1;
        m_bvalid_i   = 1'b0;
        #1;
        if (req_finish_o) begin
          done = 1'b1;
          chk("to_err_valid", 64'(err_valid_o), 64'd1);
          chk("to_err_src", 64'(err_src_o), 64'd2);
          chk("to_err_addr", 64'(err_addr_o), 64'h0000_A000);
        end else if (c > 0 && m_bready_o) begin
          resp_cyc++;
        end
      end
      chk("to_resp_cycles", 64'(resp_cyc), 64'd16);
      @(negedge clk);
      idle_inputs();
      m_bvalid_i = 1'b1;
      m_bresp_i  = 2'b10;
      #1;
      chk("to_late_b_bready", 64'(m_bready_o), 64'd1);
      chk("to_late_b_quiet", 64'({req_finish_o, err_valid_o}), 64'd0);
      @(negedge clk);
      idle_inputs();
    end
`endif

    // Randomized bursts checked against the transaction-level expectations.
    for (int r = 0; r < 25; r++) begin
      rv.addr    = {$urandom_range(0, 32'hFFFF), 6'd0, 10'd0} | 32'($urandom_range(0, 1023) << 6);
      rv.alen    = 8'($urandom_range(0, 15));
      rv.size    = 3'($urandom_range(0, 6));
      rv.strb    = {$urandom(), $urandom()};
      rv.bresp   = 2'($urandom_range(0, 3));
      rv.aw_dly  = $urandom_range(0, 3);
      rv.wr_mode = 2;
      rv.gap     = 1'($urandom_range(0, 1));
      rv.b_dly   = $urandom_range(0, 3);
      rv.exp_lat = -1;
      rv.exp_err = (rv.bresp == 2'b10) || (rv.bresp == 2'b11);
      rv.exp_src = (rv.bresp == 2'b11) ? 2'd1 : 2'd0;
      run_burst($sformatf("rand%0d", r), rv);
    end

    @(negedge clk);
    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
